// File: rtl/json_stream_pkg.sv
// Shared types for the JSON packet parser input path: beat payload and arbiter FSM states.
package json_stream_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

endpackage

// File: rtl/json_stream_arb_rr_pick.sv
// Combinational round-robin pick: first set request searching upward from last_grant+1.
module rr_pick #(
    parameter  int unsigned NUM_SRC = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   idx_c,
    output logic               found_c
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        idx_c   = '0;
        found_c = 1'b0;
        cand    = 0;
        for (int k = int'(NUM_SRC); k > 0; k--) begin
            cand = (int'(last_grant) + k) % int'(NUM_SRC);
            if (req[cand]) begin
                idx_c   = IDX_W'(cand);
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/json_stream_arb.sv
// Packet-level round-robin arbiter feeding the JSON parser through a one-deep registered output stage.
module json_stream_arb #(
    parameter  int unsigned NUM_SRC = 2,
    parameter  int unsigned DATA_W  = 64,
    parameter  int unsigned KEEP_W  = DATA_W / 8,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DATA_W-1:0] s_data,
    input  logic [NUM_SRC*KEEP_W-1:0] s_keep,
    input  logic [NUM_SRC-1:0]        s_last,
    input  logic [NUM_SRC-1:0]        s_valid,
    output logic [NUM_SRC-1:0]        s_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic [KEEP_W-1:0]         m_keep,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          pkt_count
);

    import json_stream_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               pick_found_c;
    logic               take_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic [KEEP_W-1:0]  sel_keep_c;
    logic               sel_last_c;
    logic               sel_valid_c;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .req        (s_valid),
        .last_grant (last_grant),
        .idx_c      (pick_idx_c),
        .found_c    (pick_found_c)
    );

    // Mux of the currently granted source's beat.
    always_comb begin
        sel_data_c  = '0;
        sel_keep_c  = '0;
        sel_last_c  = 1'b0;
        sel_valid_c = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_id == IDX_W'(i)) begin
                sel_data_c  = s_data[i*DATA_W +: DATA_W];
                sel_keep_c  = s_keep[i*KEEP_W +: KEEP_W];
                sel_last_c  = s_last[i];
                sel_valid_c = s_valid[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus per-source accept; s_ready follows m_ready combinationally.
    always_comb begin
        state_nxt = state;
        s_ready   = '0;
        take_c    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found_c) begin
                    state_nxt = PASS;
                end
            end
            PASS: begin
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    s_ready[i] = (grant_id == IDX_W'(i)) && (!m_valid || m_ready);
                end
                take_c = sel_valid_c && (!m_valid || m_ready);
                if (take_c && sel_last_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id   <= '0;
            last_grant <= IDX_W'(NUM_SRC - 1);
            busy       <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
            pkt_count  <= '0;
        end else begin
            busy <= (state_nxt == PASS);
            if (state == IDLE && pick_found_c) begin
                grant_id   <= pick_idx_c;
                last_grant <= pick_idx_c;
            end
            // A new load takes priority over draining, so m_valid stays up on simultaneous drain+load.
            if (take_c) begin
                m_valid <= 1'b1;
                m_data  <= sel_data_c;
                m_keep  <= sel_keep_c;
                m_last  <= sel_last_c;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (m_valid && m_ready && m_last) begin
                pkt_count <= pkt_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_json_stream_arb.sv
// Randomized self-checking bench for json_stream_arb against a packet-order scoreboard model.
module tb_json_stream_arb;

    import json_stream_pkg::*;

    localparam int unsigned NSRC = 3;
    localparam int unsigned CW   = 4;
    localparam int unsigned IW   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NSRC*DATA_W-1:0]   s_data;
    logic [NSRC*KEEP_W-1:0]   s_keep;
    logic [NSRC-1:0]          s_last;
    logic [NSRC-1:0]          s_valid;
    logic [NSRC-1:0]          s_ready;
    logic [DATA_W-1:0]        m_data;
    logic [KEEP_W-1:0]        m_keep;
    logic                     m_last;
    logic                     m_valid;
    logic                     m_ready;
    logic [IW-1:0]            grant_id;
    logic                     busy;
    logic [CW-1:0]            pkt_count;

    json_stream_arb #(
        .NUM_SRC (NSRC),
        .DATA_W  (DATA_W),
        .KEEP_W  (KEEP_W),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_last    (s_last),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    beat_t        src_q [NSRC][$];
    beat_t        exp_q [$];
    logic [7:0]   pkt_src_q [$];
    logic [NSRC-1:0] in_pkt;
    bit           out_in_pkt;
    bit           drop_en;
    bit           rst_req;
    bit           last_hs;
    int           rdy_mode;
    int           mdl_last;
    int           seq;
    int           n_checks;
    int           n_errs;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic gen_pkt(input int src, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {8'(src), 24'(seq), 32'($urandom)};
            b.keep = 8'($urandom);
            b.last = (k == len - 1);
            seq++;
            src_q[src].push_back(b);
        end
    endtask

    // Whole packets leave in round-robin order over sources that still hold packets.
    task automatic build_exp();
        beat_t tq [NSRC][$];
        beat_t b;
        int    nxt;
        int    j;
        for (int i = 0; i < int'(NSRC); i++) tq[i] = src_q[i];
        do begin
            nxt = -1;
            for (int k = 1; k <= int'(NSRC); k++) begin
                j = (mdl_last + k) % int'(NSRC);
                if (nxt < 0 && tq[j].size() > 0) nxt = j;
            end
            if (nxt >= 0) begin
                do begin
                    b = tq[nxt].pop_front();
                    exp_q.push_back(b);
                end while (!b.last);
                mdl_last = nxt;
            end
        end while (nxt >= 0);
    endtask

    task automatic step();
        beat_t e;
        @(posedge clk);
        #1;
        rst = rst_req;
        last_hs = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (src_q[i].size() > 0) begin
                s_valid[i] = (in_pkt[i] && drop_en) ? (($urandom % 4) != 0) : 1'b1;
                s_data[i*DATA_W +: DATA_W] = src_q[i][0].data;
                s_keep[i*KEEP_W +: KEEP_W] = src_q[i][0].keep;
                s_last[i] = src_q[i][0].last;
            end else begin
                s_valid[i] = 1'b0;
                s_data[i*DATA_W +: DATA_W] = '0;
                s_keep[i*KEEP_W +: KEEP_W] = '0;
                s_last[i] = 1'b0;
            end
        end
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (($urandom % 3) != 0);
            default: m_ready = 1'b0;
        endcase
        @(negedge clk);
        if (rst) begin
            in_pkt = '0;
            out_in_pkt = 1'b0;
        end else begin
            for (int i = 0; i < int'(NSRC); i++) begin
                if (s_valid[i] && s_ready[i]) begin
                    in_pkt[i] = !src_q[i][0].last;
                    void'(src_q[i].pop_front());
                end
            end
            if (m_valid && m_ready) begin
                last_hs = 1'b1;
                if (!out_in_pkt) pkt_src_q.push_back(m_data[63:56]);
                out_in_pkt = !m_last;
                if (exp_q.size() == 0) begin
                    check_eq("beat_expected", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", m_data, e.data);
                    check_eq("out_keep", 64'(m_keep), 64'(e.keep));
                    check_eq("out_last", 64'(m_last), 64'(e.last));
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            step();
            c++;
        end
        check_eq("drain_done", 64'(exp_q.size()), 64'(0));
        step();
        step();
    endtask

    task automatic reset_dut();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        step();
        mdl_last = int'(NSRC) - 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0]  mv;
        logic [63:0] held;
        logic [31:0] ord;
        int          prev;
        int          n;
        n_checks = 0;
        n_errs   = 0;
        seq      = 0;
        rst      = 1'b1;
        rst_req  = 1'b1;
        s_valid  = '0;
        s_data   = '0;
        s_keep   = '0;
        s_last   = '0;
        m_ready  = 1'b1;
        rdy_mode = 0;
        drop_en  = 1'b0;
        in_pkt   = '0;
        out_in_pkt = 1'b0;

        reset_dut();
        check_eq("rst_m_valid", 64'(m_valid), 64'(0));
        check_eq("rst_m_data", m_data, 64'(0));
        check_eq("rst_m_keep", 64'(m_keep), 64'(0));
        check_eq("rst_m_last", 64'(m_last), 64'(0));
        check_eq("rst_s_ready", 64'(s_ready), 64'(0));
        check_eq("rst_grant_id", 64'(grant_id), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_pkt_count", 64'(pkt_count), 64'(0));

        // Single 3-beat packet: output valid exactly two to four cycles after the request.
        gen_pkt(0, 3);
        build_exp();
        mv = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            mv[c] = m_valid;
            if (c == 1) check_eq("t1_busy_pass", 64'(busy), 64'(1));
        end
        check_eq("t1_valid_window", 64'(mv), 64'(6'b011100));
        check_eq("t1_pkt_count", 64'(pkt_count), 64'(1));
        check_eq("t1_busy_idle", 64'(busy), 64'(0));
        check_eq("t1_exp_empty", 64'(exp_q.size()), 64'(0));

        // Two competing sources from reset alternate packet by packet.
        reset_dut();
        pkt_src_q.delete();
        gen_pkt(0, 2);
        gen_pkt(1, 2);
        gen_pkt(0, 2);
        gen_pkt(1, 2);
        build_exp();
        drain(100);
        check_eq("t2_pkt_count", 64'(pkt_count), 64'(4));
        ord = '0;
        for (int i = 0; i < pkt_src_q.size(); i++) ord = (ord << 8) | 32'(pkt_src_q[i]);
        check_eq("t2_grant_order", 64'(ord), 64'(32'h00010001));

        // Backpressure mid-packet: output holds and no source is accepted.
        gen_pkt(0, 4);
        build_exp();
        step();
        step();
        step();
        rdy_mode = 2;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) held = m_data;
            check_eq("t3_hold_valid", 64'(m_valid), 64'(1));
            check_eq("t3_hold_data", m_data, held);
            check_eq("t3_s_ready_low", 64'(s_ready), 64'(0));
        end
        rdy_mode = 0;
        drain(100);

        // Back-to-back single-beat packets from source 1: one beat every two cycles.
        for (int k = 0; k < 4; k++) gen_pkt(1, 1);
        build_exp();
        prev = -1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            step();
            if (last_hs) begin
                check_eq("t4_grant_id", 64'(grant_id), 64'(1));
                if (prev >= 0) check_eq("t4_beat_gap", 64'(c - prev), 64'(2));
                prev = c;
            end
        end
        drain(10);

        // Reset during beat 2 of a 4-beat packet; remainder is re-arbitrated with source 0 first.
        gen_pkt(0, 4);
        build_exp();
        step();
        step();
        check_eq("t5_busy_before", 64'(busy), 64'(1));
        gen_pkt(1, 2);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        check_eq("t5_m_valid", 64'(m_valid), 64'(0));
        check_eq("t5_busy", 64'(busy), 64'(0));
        check_eq("t5_pkt_count", 64'(pkt_count), 64'(0));
        exp_q.delete();
        mdl_last = int'(NSRC) - 1;
        build_exp();
        step();
        check_eq("t5_first_grant", 64'(grant_id), 64'(0));
        drain(100);
        check_eq("t5_pkt_after", 64'(pkt_count), 64'(2));

        // Random traffic with backpressure and source gaps; counter wraps at 16.
        reset_dut();
        rdy_mode = 1;
        drop_en  = 1'b1;
        for (int p = 0; p < 17; p++) gen_pkt(int'($urandom_range(0, NSRC - 1)), int'($urandom_range(1, 4)));
        build_exp();
        drain(3000);
        check_eq("t6_wrap_17", 64'(pkt_count), 64'(1));
        n = int'($urandom_range(5, 25));
        for (int p = 0; p < n; p++) gen_pkt(int'($urandom_range(0, NSRC - 1)), int'($urandom_range(1, 4)));
        build_exp();
        drain(4000);
        check_eq("t6_count_rand", 64'(pkt_count), 64'(CW'(17 + n)));
        rdy_mode = 0;
        drop_en  = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
